instr_byte_queue: RTL
=====================

// Module: instr_byte_queue
// PURPOSE
//  Byte-granular instruction prefetch queue between the I-cache fetch port and the decoder.
//  Accepts 16-byte fetch lines and presents the next 16 unconsumed bytes as a window.
//  Byte 0 sits at window[7:0], which is the input format of the lshift128b_8 aligner.
//  The decoder retires 1-16 bytes per cycle. Supports redirect flush with an entry offset
//  into the first line after the flush.
// PARAMETERS
//  LINES  2  storage depth in 16-byte lines. Capacity CAP = 16*LINES bytes. Legal range 2..4.
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      asynchronous active-low reset
//  flush          in   1      redirect: discard all queued bytes
//  flush_offset   in   4      bytes to skip in the first line accepted after a flush
//  fetch_valid    in   1      fetch_data holds a valid 16-byte line
//  fetch_data     in   128    line bytes, byte i at [8i+7:8i]
//  fetch_ready    out  1      queue can accept a line this cycle
//  consume_valid  in   1      decoder retires consume_len bytes
//  consume_len    in   5      bytes retired, 1..16 (0 is treated as no consume)
//  window         out  128    next 16 queued bytes, byte 0 at [7:0]; bytes >= avail are 0
//  avail_bytes    out  6      queued byte count, 0..CAP
//  window_full    out  1      avail_bytes >= 16
//  err_underflow  out  1      1-cycle pulse: consume_len > avail_bytes
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - buffer cleared; avail_bytes=0; skip register=0.
//    - window=0, window_full=0, err_underflow=0; fetch_ready=1 once rst_n deasserts.
//  - Storage: one register buf[8*CAP-1:0] plus count (avail_bytes). The queue head is always byte 0.
//  - fetch_ready = (count <= CAP-16). It is combinational from the registered count only,
//    never from the same-cycle consume.
//  - Push occurs when fetch_valid && fetch_ready:
//    - n_in = 16 - skip.
//    - Incoming bytes are fetch_data >> (8*skip).
//    - skip clears to 0 after any push.
//  - Consume occurs when consume_valid && 1<=consume_len<=count. Then d = consume_len, otherwise d = 0.
//    - If consume_valid && consume_len > count: no bytes removed, err_underflow=1 next cycle.
//  - Same-cycle push and consume, next state:
//    - buf' = (buf >> 8*d) | (incoming << 8*(count-d)).
//    - count' = count - d + n_in.
//    - count' never exceeds CAP by the fetch_ready rule.
//  - Flush has the highest priority:
//    - count'=0, buf'=0, skip'=flush_offset.
//    - Push and consume in the flush cycle are dropped. No err_underflow is raised in a flush cycle.
//  - Latency: a pushed line is visible in window/avail_bytes on the cycle after acceptance.
//    A consume takes effect the next cycle.
//  - Outputs window, avail_bytes and window_full are driven from registers/buf only
//    (no input-to-output combinational path).
//  - Bytes above count inside buf must read as zero at all times.
//  - consume_len=16 with count>=16 empties the whole window in one cycle.
//  - A flush with a repeated nonzero flush_offset before any push overwrites skip
//    with the latest value.
// TESTING
//  1. Reset, then push line 0x0F..0x00. Next cycle: avail=16, window=0x0F0E..0100, window_full=1.
//  2. LINES=2. Push 2 lines -> avail=32, fetch_ready=0. Push held 3 cycles: no change.
//     Consume 16 -> fetch_ready=1 next cycle.
//  3. avail=20. Consume 3 and push a line in the same cycle -> avail=33? No: fetch_ready=0 at 20,
//     so avail=17, window byte0 = old byte3.
//  4. flush=1, flush_offset=5, then push 0x0F..0x00 -> avail=11, window[7:0]=0x05,
//     window[127:88]=0.
//  5. avail=4, consume_len=6 -> avail stays 4, err_underflow pulses for exactly one cycle.
//  6. Drop rst_n mid-stream with avail=24 -> outputs zero immediately, before the next clk edge.

Source files
------------

// File: rtl/instr_byte_queue.sv
// Byte-granular instruction prefetch queue: accepts 16-byte fetch lines and presents
// the next 16 unconsumed bytes to the decoder with byte 0 at window_o[7:0].
module instr_byte_queue #(
   parameter  int LINES = 2,
   localparam int CAP   = 16 * LINES,
   localparam int CW    = $clog2(CAP + 1),
   localparam int BW    = 8 * CAP
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          flush_i,
   input  logic [3:0]    flush_offset_i,
   input  logic          fetch_valid_i,
   input  logic [127:0]  fetch_data_i,
   output logic          fetch_ready_o,
   input  logic          consume_valid_i,
   input  logic [4:0]    consume_len_i,
   output logic [127:0]  window_o,
   output logic [CW-1:0] avail_bytes_o,
   output logic          window_full_o,
   output logic          err_underflow_o
);

   // Handshake: a line is taken on a rising edge where fetch_valid_i && fetch_ready_o.
   // fetch_ready_o depends on the registered count only, never on a same-cycle consume.

   logic [BW-1:0] buf_q, buf_d;
   logic [CW-1:0] count_q, count_d;
   logic [3:0]    skip_q, skip_d;
   logic          err_q, err_d;

   logic          push;
   logic          cons_ok;
   logic          under;
   logic [CW-1:0] len_ext;
   logic [CW-1:0] d;
   logic [CW-1:0] n_in;
   logic [BW-1:0] incoming;

   assign fetch_ready_o = (count_q <= CW'(CAP - 16));

   always_comb begin
      push     = fetch_valid_i && fetch_ready_o;
      len_ext  = CW'(consume_len_i);
      cons_ok  = consume_valid_i && (consume_len_i != 5'd0) && (len_ext <= count_q);
      under    = consume_valid_i && (len_ext > count_q);
      d        = cons_ok ? len_ext : '0;
      // Skipped leading bytes shift out; zeros fill the top so bytes above count stay zero.
      incoming = BW'(fetch_data_i >> {skip_q, 3'b000});
      n_in     = push ? (CW'(16) - CW'(skip_q)) : '0;

      buf_d    = buf_q >> {d, 3'b000};
      if (push) begin
         buf_d = buf_d | (incoming << {(count_q - d), 3'b000});
      end
      count_d  = count_q - d + n_in;
      skip_d   = push ? 4'd0 : skip_q;
      err_d    = under;

      if (flush_i) begin
         buf_d   = '0;
         count_d = '0;
         skip_d  = flush_offset_i;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         buf_q   <= '0;
         count_q <= '0;
         skip_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         buf_q   <= buf_d;
         count_q <= count_d;
         skip_q  <= skip_d;
         err_q   <= err_d;
      end
   end

   assign window_o        = buf_q[127:0];
   assign avail_bytes_o   = count_q;
   assign window_full_o   = (count_q >= CW'(16));
   assign err_underflow_o = err_q;

endmodule
